// File: rtl/csr_timer.sv
// Free-running XLEN-bit up-counter with a synchronous load; val_o is the register, visible the cycle after each edge.
// No backpressure: it advances every clk edge. Define CSR_TIMER_OVF_EN to add the sticky wrap flag ovf_o.
module csr_timer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] val_i,
  input  logic            we_i,
`ifdef CSR_TIMER_OVF_EN
  output logic            ovf_o,
`endif
  output logic [XLEN-1:0] val_o
);

  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            load;

  // An unknown strobe falls to the else branch, so it never loads.
  always_comb begin
    load = 1'b0;
    if (we_i == 1'b1) load = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
    if (load) cnt_d = val_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign val_o = cnt_q;

`ifdef CSR_TIMER_OVF_EN
  logic ovf_q, ovf_d;

  // Only a genuine increment out of all-ones sets the flag; a load always clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (load)            ovf_d = 1'b0;
    else if (&cnt_q)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Directed test of csr_timer: reset, increment, load priority, carry, wrap, async reset.
module tb_csr_timer;

  logic        clk;
  logic        rst_n;
  logic [63:0] val_i;
  logic        we_i;
  logic [63:0] val_o;
`ifdef CSR_TIMER_OVF_EN
  logic        ovf_o;
`endif

  int tests = 0;
  int fails = 0;

  csr_timer #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .val_i (val_i),
    .we_i  (we_i),
`ifdef CSR_TIMER_OVF_EN
    .ovf_o (ovf_o),
`endif
    .val_o (val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we_i  = 1'b0;
    val_i = 64'h0;
    #3;
    chk("reset_val", val_o, 64'h0);
`ifdef CSR_TIMER_OVF_EN
    chk("reset_ovf", {63'h0, ovf_o}, 64'h0);
`endif

    // Load attempts during reset are ignored.
    we_i  = 1'b1;
    val_i = 64'hDEAD;
    step(2);
    chk("reset_ignores_load", val_o, 64'h0);

    we_i  = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("first_inc", val_o, 64'h1);
    step(4);
    chk("five_edges", val_o, 64'h5);

    // Carry into the upper word.
    we_i  = 1'b1;
    val_i = 64'h0000_0001_FFFF_FFF0;
    step(1);
    chk("load_carry_base", val_o, 64'h0000_0001_FFFF_FFF0);
    we_i = 1'b0;
    step(1);
    chk("load_plus_one", val_o, 64'h0000_0001_FFFF_FFF1);
    step(15);
    chk("carry_upper", val_o, 64'h0000_0002_0000_0000);

    // Wrap to zero.
    we_i  = 1'b1;
    val_i = 64'hFFFF_FFFF_FFFF_FFFE;
    step(1);
    chk("load_fe", val_o, 64'hFFFF_FFFF_FFFF_FFFE);
    we_i = 1'b0;
    step(1);
    chk("at_ones", val_o, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef CSR_TIMER_OVF_EN
    chk("ovf_before_wrap", {63'h0, ovf_o}, 64'h0);
`endif
    step(1);
    chk("wrap_zero", val_o, 64'h0);
`ifdef CSR_TIMER_OVF_EN
    chk("ovf_set", {63'h0, ovf_o}, 64'h1);
`endif
    step(2);
`ifdef CSR_TIMER_OVF_EN
    chk("ovf_sticky", {63'h0, ovf_o}, 64'h1);
`endif
    chk("after_wrap", val_o, 64'h2);

    // Loading zero clears the flag.
    we_i  = 1'b1;
    val_i = 64'h0;
    step(1);
    chk("load_zero", val_o, 64'h0);
`ifdef CSR_TIMER_OVF_EN
    chk("ovf_clr_load", {63'h0, ovf_o}, 64'h0);
`endif

    // Held load follows val_i, counting resumes after release.
    val_i = 64'h1234;
    step(1);
    chk("hold_load_1", val_o, 64'h1234);
    step(1);
    chk("hold_load_2", val_o, 64'h1234);
    step(1);
    chk("hold_load_3", val_o, 64'h1234);
    we_i = 1'b0;
    step(1);
    chk("hold_release", val_o, 64'h1235);

    // Load of all-ones, then a load on the would-be wrap edge wins.
    we_i  = 1'b1;
    val_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1);
    chk("load_ones", val_o, 64'hFFFF_FFFF_FFFF_FFFF);
    val_i = 64'h7;
    step(1);
    chk("load_beats_wrap", val_o, 64'h7);
`ifdef CSR_TIMER_OVF_EN
    chk("ovf_no_set_on_load", {63'h0, ovf_o}, 64'h0);
`endif

    // Asynchronous reset mid-cycle.
    val_i = 64'h54;
    step(1);
    we_i = 1'b0;
    step(1);
    chk("at_55", val_o, 64'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", val_o, 64'h0);

    // Reset overrides a load; first edge after release increments from 0.
    we_i  = 1'b1;
    val_i = 64'h99;
    step(2);
    chk("reset_over_load", val_o, 64'h0);
    we_i  = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("release_inc", val_o, 64'h1);

    // First edge after release loads when we_i is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_again", val_o, 64'h0);
    we_i  = 1'b1;
    val_i = 64'h77;
    rst_n = 1'b1;
    step(1);
    chk("release_load", val_o, 64'h77);
    we_i = 1'b0;
    step(1);
    chk("release_load_inc", val_o, 64'h78);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
CSR_TIMER -- requirements
Module: csr_timer

Interface
REQ-001 Parameter XLEN, default 64: counter width in bits; legal values 32 to 64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; clears all state.
REQ-004 val_i  input  XLEN  load value for the counter.
REQ-005 we_i  input  1  load strobe; val_i is written when high at a rising clk edge.
REQ-006 val_o  output  XLEN  current counter value, driven directly from the counter register with no combinational path from inputs.
REQ-007 ovf_o  output  1  sticky wrap flag; present only when CSR_TIMER_OVF_EN is defined.

Function
REQ-008 Free-running up-counter of XLEN bits; rising clk edge with we_i=0 and rst_n=1: counter <= counter + 1.
REQ-009 Rising clk edge with we_i=1: counter <= val_i; no increment on that edge (load has priority).
REQ-010 Load latency: val_o equals the loaded value in the cycle after the load edge, and equals that value + 1 one edge later.
REQ-011 we_i held high for N edges: val_o follows val_i each edge; counting resumes on the first edge with we_i=0.
REQ-012 Wrap-around: all-ones + 1 = 0 modulo 2^XLEN; no saturation and no stall.
REQ-013 val_o is stable for the entire clock period; a read of the low and high halves in the same cycle is coherent.
REQ-014 Unknown (X/Z) value on we_i is treated as 0 (no load).
REQ-015 There is no enable input; the counter advances on every clk edge outside reset.

Reset
REQ-016 rst_n low forces counter = 0 (val_o = 0) immediately, without waiting for a clock edge.
REQ-017 rst_n low forces ovf_o = 0, when ovf_o is present.
REQ-018 While rst_n is low, we_i and val_i are ignored.
REQ-019 The first rising edge after rst_n deasserts increments from 0, or loads val_i if we_i=1.
REQ-020 Reset asserted mid-count or during a load overrides both; the counter is 0 after release.

Configuration
REQ-021 Macro CSR_TIMER_OVF_EN defined: ovf_o exists and is set on any increment edge where counter = all-ones (wrap to 0).
REQ-022 With CSR_TIMER_OVF_EN defined: once set, ovf_o stays set until a load edge (we_i=1) or reset clears it.
REQ-023 With CSR_TIMER_OVF_EN defined: a load of val_i = all-ones does not set ovf_o.
REQ-024 With CSR_TIMER_OVF_EN defined: the flag is set on the following wrap increment, unless that edge is itself a load.
REQ-025 Without CSR_TIMER_OVF_EN: ovf_o and its logic are absent, and all other behaviour is identical.

Verification
REQ-026 Reset then release for 5 edges: val_o = 0 during reset and 5 after the 5 edges.
REQ-027 Load 0x0000_0001_FFFF_FFF0 with we_i=1 for one edge, then idle 0x10 edges: val_o = 0x0000_0002_0000_0000 (carry into upper word).
REQ-028 Load 0xFFFF_FFFF_FFFF_FFFE, then 2 idle edges: val_o = 0, and ovf_o = 1 when CSR_TIMER_OVF_EN is defined.
REQ-029 we_i=1 with val_i = 0x1234 for 3 edges, then release: val_o = 0x1234 during the load edges and 0x1235 one edge after release.
REQ-030 Assert rst_n mid-cycle while val_o = 0x55: val_o = 0 before the next clk edge.
REQ-031 With the ovf_o flag set, load 0x0: ovf_o = 0 and val_o = 0 after that edge.
